// File: rtl/dac7611_frame_ctrl_pkg.sv
// Shared definitions for the DAC7611 frame controller: FSM encoding and
// DAC word constants.
// No ports; imported by dac7611_frame_ctrl and its shift lanes.
package dac7611_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int              DAC_WIDTH    = 12;
  localparam logic [11:0]     DAC_MIDSCALE = 12'h800;

endpackage

// File: rtl/dac7611_frame_ctrl_shift_lane.sv
// Purpose: WIDTH-bit load/shift register with a registered serial output, MSB first.
// Latency: MSB on o_sdo the cycle after i_load; each i_shift advances one bit next cycle.
// Backpressure: none; the parent sequences i_load/i_shift/i_clr.
// Ports: i_clk, i_rst (sync, active-high), i_load/i_shift/i_clr controls,
//        i_data parallel word, o_sdo serial data pin.
module dac7611_frame_ctrl_shift_lane #(
  parameter int WIDTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_sdo
);

  logic [WIDTH-1:0] r_sreg;
  logic             r_sdo;

  // The MSB goes straight to the output register on load, so r_sreg only
  // holds the bits still waiting to be presented.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_sreg <= '0;
      r_sdo  <= 1'b0;
    end else if (i_load) begin
      r_sreg <= {i_data[WIDTH-2:0], 1'b0};
      r_sdo  <= i_data[WIDTH-1];
    end else if (i_shift) begin
      r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
      r_sdo  <= r_sreg[WIDTH-1];
    end
  end

  assign o_sdo = r_sdo;

endmodule

// File: rtl/dac7611_frame_ctrl.sv
// Purpose: serialises two WIDTH-bit samples to two DAC7611s on a shared clk/latch pair.
// Latency: first bit 2 cycles after strobe; frame is (2*WIDTH+1)*DIV cycles incl. latch.
// Backpressure: none; one-deep pending buffer, overwrite sets sticky overrun.
// Ports: clk, rst (sync, active-high), en, mute, smp_strobe, sample_a, sample_b in;
//        dac_clk, dac_le, dac_dat_a, dac_dat_b, busy, overrun out (all registered).
module dac7611_frame_ctrl
  import dac7611_frame_ctrl_pkg::*;
#(
  parameter int DIV   = 2,
  parameter int WIDTH = DAC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mute,
  input  logic             smp_strobe,
  input  logic [WIDTH-1:0] sample_a,
  input  logic [WIDTH-1:0] sample_b,
  output logic             dac_clk,
  output logic             dac_le,
  output logic             dac_dat_a,
  output logic             dac_dat_b,
  output logic             busy,
  output logic             overrun
);

  localparam int HW = $clog2(DIV + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [HW-1:0] HC_LAST = HW'(DIV - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIDSCALE = (WIDTH == DAC_WIDTH) ? WIDTH'(DAC_MIDSCALE)
                                                               : {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state, w_state_nxt;
  logic [HW-1:0]    r_hcnt, w_hcnt_nxt;
  logic [BW-1:0]    r_bcnt, w_bcnt_nxt;
  logic             r_clk, w_clk_nxt;
  logic             r_le, w_le_nxt;
  logic             r_busy;
  logic             r_pend_vld;
  logic [WIDTH-1:0] r_pend_a, r_pend_b;
  logic             r_overrun;
  logic             w_cap, w_load, w_shift, w_clr;

  assign w_cap = smp_strobe & en;

  // Next-state and next-pin values; pins themselves are registered below.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_bcnt_nxt  = r_bcnt;
    w_clk_nxt   = r_clk;
    w_le_nxt    = r_le;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_vld) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
          w_hcnt_nxt  = HC_LAST;
          w_bcnt_nxt  = BC_LAST;
          w_clk_nxt   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (r_hcnt != '0) begin
          w_hcnt_nxt = r_hcnt - HW'(1);
        end else begin
          w_hcnt_nxt = HC_LAST;
          if (!r_clk) begin
            w_clk_nxt = 1'b1;
          end else if (r_bcnt == '0) begin
            // Last high phase done: drop LE and park data low.
            w_state_nxt = ST_LATCH;
            w_clk_nxt   = 1'b0;
            w_le_nxt    = 1'b0;
            w_clr       = 1'b1;
          end else begin
            // Falling edge of dac_clk is the only point data advances.
            w_bcnt_nxt = r_bcnt - BW'(1);
            w_clk_nxt  = 1'b0;
            w_shift    = 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (r_hcnt != '0) begin
          w_hcnt_nxt = r_hcnt - HW'(1);
        end else begin
          w_le_nxt    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_clk   <= 1'b0;
      r_le    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_clk   <= w_clk_nxt;
      r_le    <= w_le_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Pending buffer. A strobe coinciding with a load refills the buffer after
  // the load has taken the old contents, so that case is not an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_pend_a   <= '0;
      r_pend_b   <= '0;
      r_overrun  <= 1'b0;
    end else if (w_cap) begin
      r_pend_a   <= mute ? MIDSCALE : sample_a;
      r_pend_b   <= mute ? MIDSCALE : sample_b;
      r_pend_vld <= 1'b1;
      if (r_pend_vld && !w_load) begin
        r_overrun <= 1'b1;
      end
    end else if (w_load) begin
      r_pend_vld <= 1'b0;
    end
  end

  dac7611_frame_ctrl_shift_lane #(.WIDTH(WIDTH)) u_lane_a (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clr   (w_clr),
    .i_data  (r_pend_a),
    .o_sdo   (dac_dat_a)
  );

  dac7611_frame_ctrl_shift_lane #(.WIDTH(WIDTH)) u_lane_b (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clr   (w_clr),
    .i_data  (r_pend_b),
    .o_sdo   (dac_dat_b)
  );

  assign dac_clk = r_clk;
  assign dac_le  = r_le;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule
